dp_bram_mc_arbiter: RTL and testbench
=====================================

// Module: dp_bram_mc_arbiter
// PURPOSE
// - Parametrised N-client arbiter in front of one true dual-port BRAM.
// - Each cycle, grants up to two client requests: one to port A, one to port B.
// - Drives the BRAM port signals from registers.
// - Returns read data to the originating client through a tag pipeline matched to BRAM read latency.
// - Sits between the convolution engine's requesters (kernel fetch, feature-map read/write) and the BRAM.
// - Replaces hard-wired single-owner port usage.
// PARAMETERS
// - NUM_CLIENTS   4   number of requesters, >=2
// - DATA_WIDTH    16  BRAM word width
// - ADDR_WIDTH    10  BRAM address width
// - READ_LATENCY  1   BRAM cycles from registered en to valid data_out, 1..3
// PORTS
// - clk         in   1           clock, all logic rising-edge
// - rst         in   1           reset, asynchronous, active-high
// - cl_req      in   N           client request, held until granted
// - cl_we       in   N           client write (1) / read (0)
// - cl_addr     in   N*AW        client address, flattened, client i at [i*AW +: AW]
// - cl_wdata    in   N*DW        client write data, flattened
// - cl_gnt      out  N           grant, combinational, one-cycle pulse per accepted request
// - cl_rvalid   out  N           read data valid for client i
// - cl_rdata    out  N*DW        read data, flattened, valid only with cl_rvalid
// - addr_a/b    out  AW          BRAM port address
// - data_in_a/b out  DW          BRAM port write data
// - we_a/b      out  1           BRAM port write enable
// - en_a/b      out  1           BRAM port enable
// - data_out_a/b in  DW          BRAM port read data
// BEHAVIOUR
// - Reset:
//   - rr_ptr=0.
//   - Outputs cleared: en_*/we_*/addr_*/data_in_*=0, cl_rvalid=0, cl_rdata=0.
//   - Tag pipeline flushed.
//   - Asserting rst mid-operation drops in-flight reads; no rvalid follows.
// - Grant selection (combinational):
//   - Port A: first i with cl_req[i], scanning rr_ptr, rr_ptr+1, ... mod N.
//   - Port B: next requesting client after A's winner in the same scan order.
//   - No second requester -> port B idle.
// - Accepted request: cl_gnt[i]=1 in the cycle of acceptance. Client drops or changes req next cycle.
// - Pointer update: rr_ptr <= (last granted index + 1) mod N. No grants -> rr_ptr holds.
// - Issue: next clk edge registers en_x=1, we_x, addr_x, data_in_x from the granted client. Idle port -> en_x=0, we_x=0.
// - Read path:
//   - Tag {valid, client idx} per port, delayed READ_LATENCY+1 cycles.
//   - Total latency from cl_gnt to cl_rvalid = 1 + READ_LATENCY.
//   - Port A and port B may return in the same cycle to two different clients.
//   - A client is never granted both ports in the same cycle.
// - Writes: no response. Committed at BRAM edge after issue.
// - Fully pipelined: back-to-back grants every cycle. Throughput is 2 ops/cycle.
// CONFIGURATION
// - Macro DP_BRAM_ARB_COLLISION_EN. Collision = both candidates hit the same address and at least one is a write.
// - Defined:
//   - On collision, only port A's candidate is granted.
//   - Port B's candidate gets no cl_gnt and retries.
//   - rr_ptr advances past A's winner only.
//   - Read/read to the same address is not a collision.
// - Undefined:
//   - No address compare; both candidates are granted.
//   - Requesters guarantee disjoint write addresses.
// TESTING
// - N=4, DW=16, AW=10, RL=1.
// 1. Reset: rst=1 mid-read -> en_a=en_b=0, cl_rvalid=0 next and following cycles; rr_ptr=0 after release.
// 2. Single write then read:
//    - Client 2 writes 0x1234 @0x005 -> cl_gnt[2] same cycle; en_a=1, we_a=1 next cycle.
//    - Client 2 then reads @0x005 -> cl_rvalid[2]=1, data 0x1234, 2 cycles after gnt.
// 3. Fairness: all 4 clients read continuously -> grant pairs {0,1},{2,3},{0,1}...; each client served every 2 cycles.
// 4. Dual return: clients 1 and 3 read @0x010/0x011 in the same cycle -> both cl_rvalid in the same cycle, each with its own word.
// 5. Collision, macro on:
//    - Client 0 writes @0x020, client 1 reads @0x020 -> only cl_gnt[0].
//    - cl_gnt[1] next cycle; read returns the new data.
// 6. Collision, macro off: same stimulus -> both granted in the same cycle.

Source files
------------

// File: rtl/dp_bram_mc_arbiter.sv
// Round-robin N-client arbiter for one true dual-port BRAM, up to two grants per cycle; reads return 1+READ_LATENCY cycles after cl_gnt.
// Ungranted requests simply wait; define DP_BRAM_ARB_COLLISION_EN to hold port B off same-address write hazards.
module dp_bram_mc_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CLIENTS-1:0]           cl_req,
  input  logic [NUM_CLIENTS-1:0]           cl_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]           cl_gnt,
  output logic [NUM_CLIENTS-1:0]           cl_rvalid,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_rdata,
  output logic [ADDR_WIDTH-1:0]            addr_a,
  output logic [ADDR_WIDTH-1:0]            addr_b,
  output logic [DATA_WIDTH-1:0]            data_in_a,
  output logic [DATA_WIDTH-1:0]            data_in_b,
  output logic                             we_a,
  output logic                             we_b,
  output logic                             en_a,
  output logic                             en_b,
  input  logic [DATA_WIDTH-1:0]            data_out_a,
  input  logic [DATA_WIDTH-1:0]            data_out_b
);
  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int TD = READ_LATENCY + 1;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = cl_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = cl_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    if (int'(idx) == NUM_CLIENTS - 1) return '0;
    return idx + 1'b1;
  endfunction

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] a_idx;
  logic [IW-1:0] b_idx;
  logic [IW-1:0] scan_idx;
  logic          a_cand;
  logic          b_cand;
  logic          collide;
  logic          gnt_a;
  logic          gnt_b;

  // First two requesters in round-robin order starting at rr_ptr.
  always_comb begin
    a_cand   = 1'b0;
    b_cand   = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (cl_req[scan_idx]) begin
        if (!a_cand) begin
          a_cand = 1'b1;
          a_idx  = scan_idx;
        end else if (!b_cand) begin
          b_cand = 1'b1;
          b_idx  = scan_idx;
        end
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

`ifdef DP_BRAM_ARB_COLLISION_EN
  assign collide = b_cand && (addr_arr[a_idx] == addr_arr[b_idx]) &&
                   (cl_we[a_idx] || cl_we[b_idx]);
`else
  assign collide = 1'b0;
`endif

  assign gnt_a = a_cand;
  assign gnt_b = b_cand && !collide;

  always_comb begin
    cl_gnt = '0;
    if (gnt_a) cl_gnt[a_idx] = 1'b1;
    if (gnt_b) cl_gnt[b_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      en_a      <= 1'b0;
      we_a      <= 1'b0;
      addr_a    <= '0;
      data_in_a <= '0;
      en_b      <= 1'b0;
      we_b      <= 1'b0;
      addr_b    <= '0;
      data_in_b <= '0;
    end else begin
      // B always lies after A in scan order, so it is the last winner when granted.
      if (gnt_b)      rr_ptr <= wrap_inc(b_idx);
      else if (gnt_a) rr_ptr <= wrap_inc(a_idx);
      en_a <= gnt_a;
      we_a <= gnt_a && cl_we[a_idx];
      if (gnt_a) begin
        addr_a    <= addr_arr[a_idx];
        data_in_a <= wdata_arr[a_idx];
      end
      en_b <= gnt_b;
      we_b <= gnt_b && cl_we[b_idx];
      if (gnt_b) begin
        addr_b    <= addr_arr[b_idx];
        data_in_b <= wdata_arr[b_idx];
      end
    end
  end

  logic [TD-1:0] tag_vld_a;
  logic [TD-1:0] tag_vld_b;
  logic [IW-1:0] tag_idx_a [TD];
  logic [IW-1:0] tag_idx_b [TD];

  // Stage 0 loads alongside en_x; the last stage lines up with data_out_x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_a <= '0;
      tag_vld_b <= '0;
      for (int s = 0; s < TD; s++) begin
        tag_idx_a[s] <= '0;
        tag_idx_b[s] <= '0;
      end
    end else begin
      tag_vld_a[0] <= gnt_a && !cl_we[a_idx];
      tag_idx_a[0] <= a_idx;
      tag_vld_b[0] <= gnt_b && !cl_we[b_idx];
      tag_idx_b[0] <= b_idx;
      for (int s = 1; s < TD; s++) begin
        tag_vld_a[s] <= tag_vld_a[s-1];
        tag_idx_a[s] <= tag_idx_a[s-1];
        tag_vld_b[s] <= tag_vld_b[s-1];
        tag_idx_b[s] <= tag_idx_b[s-1];
      end
    end
  end

  always_comb begin
    cl_rvalid = '0;
    cl_rdata  = '0;
    if (tag_vld_a[TD-1]) begin
      cl_rvalid[tag_idx_a[TD-1]] = 1'b1;
      cl_rdata[tag_idx_a[TD-1]*DATA_WIDTH +: DATA_WIDTH] = data_out_a;
    end
    if (tag_vld_b[TD-1]) begin
      cl_rvalid[tag_idx_b[TD-1]] = 1'b1;
      cl_rdata[tag_idx_b[TD-1]*DATA_WIDTH +: DATA_WIDTH] = data_out_b;
    end
  end

endmodule

// File: tb/tb_dp_bram_mc_arbiter.sv
// Bench for dp_bram_mc_arbiter: behavioural BRAM, reference arbitration/memory model, per-client read scoreboard.
module tb_dp_bram_mc_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  logic [N-1:0]    cl_req, cl_we, cl_gnt, cl_rvalid;
  logic [N*AW-1:0] cl_addr;
  logic [N*DW-1:0] cl_wdata, cl_rdata;
  logic [AW-1:0]   addr_a, addr_b;
  logic [DW-1:0]   data_in_a, data_in_b, data_out_a, data_out_b;
  logic            we_a, we_b, en_a, en_b;

  dp_bram_mc_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_gnt(cl_gnt), .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata),
    .addr_a(addr_a), .addr_b(addr_b), .data_in_a(data_in_a), .data_in_b(data_in_b),
    .we_a(we_a), .we_b(we_b), .en_a(en_a), .en_b(en_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b));

  always #5 clk = ~clk;

  // Read-first true dual-port BRAM with one cycle of read latency.
  logic [DW-1:0] bram [1<<AW];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) bram[i] <= '0;
    end else begin
      if (en_a) begin
        if (we_a) bram[addr_a] <= data_in_a;
        data_out_a <= bram[addr_a];
      end
      if (en_b) begin
        if (we_b) bram[addr_b] <= data_in_b;
        data_out_b <= bram[addr_b];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [DW-1:0] ref_mem [1<<AW];
  int            ref_rr;
  logic [DW-1:0] exp_d [N][$];
  int            exp_c [N][$];

  // Client driver state.
  logic [N-1:0]  d_req, d_we;
  logic [AW-1:0] d_addr [N];
  logic [DW-1:0] d_wd   [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply();
    cl_req = d_req;
    cl_we  = d_we;
    for (int i = 0; i < N; i++) begin
      cl_addr[i*AW +: AW]  = d_addr[i];
      cl_wdata[i*DW +: DW] = d_wd[i];
    end
  endtask

  task automatic serve(input int c);
    if (d_we[c]) begin
      ref_mem[d_addr[c]] = d_wd[c];
    end else begin
      exp_d[c].push_back(ref_mem[d_addr[c]]);
      exp_c[c].push_back(cyc + 1 + RL);
    end
    d_req[c] = 1'b0;
  endtask

  // One cycle: drive, predict grants from the round-robin rule, compare, advance.
  task automatic step();
    int lst[$];
    int a, b, j;
    logic [N-1:0] eg;
    apply();
    #1;
    lst = {};
    for (int k = 0; k < N; k++) begin
      j = (ref_rr + k) % N;
      if (d_req[j]) lst.push_back(j);
    end
    a = -1; b = -1; eg = '0;
    if (lst.size() > 0) a = lst[0];
    if (lst.size() > 1) b = lst[1];
`ifdef DP_BRAM_ARB_COLLISION_EN
    if (b >= 0 && d_addr[a] == d_addr[b] && (d_we[a] || d_we[b])) b = -1;
`endif
    if (a >= 0) begin eg[a] = 1'b1; serve(a); ref_rr = (a + 1) % N; end
    if (b >= 0) begin eg[b] = 1'b1; serve(b); ref_rr = (b + 1) % N; end
    check("cl_gnt", cl_gnt, eg);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int c, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    d_req[c] = 1'b1; d_we[c] = we; d_addr[c] = ad; d_wd[c] = wd;
  endtask

  // Scoreboard monitor: every returned read must match the head of its client's queue.
  logic [DW-1:0] mon_d;
  int            mon_c;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (cl_rvalid[i]) begin
          if (exp_d[i].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rvalid_unexpected client %0d @cyc %0d: got data 0x%0h, expected no response", i, cyc, cl_rdata[i*DW +: DW]);
          end else begin
            mon_d = exp_d[i].pop_front();
            mon_c = exp_c[i].pop_front();
            check($sformatf("rdata_c%0d", i), cl_rdata[i*DW +: DW], mon_d);
            check($sformatf("rlat_c%0d", i), cyc, mon_c);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    ref_rr = 0;
    d_req = '0; d_we = '0;
    for (int i = 0; i < N; i++) begin d_addr[i] = '0; d_wd[i] = '0; end
    apply();
    @(negedge clk);
    @(negedge clk);
    // Reset state
    check("rst_en", {en_a, en_b, we_a, we_b}, 4'b0000);
    check("rst_addr", {addr_a, addr_b}, '0);
    check("rst_din", {data_in_a, data_in_b}, '0);
    check("rst_rvalid", cl_rvalid, '0);
    check("rst_rdata", cl_rdata, '0);
    mem_clr = 1'b0;
    rst = 1'b0;

    // Single write then read by client 2
    set_req(2, 1'b1, 10'h005, 16'h1234);
    step();
    check("wr_en_a", {en_a, we_a}, 2'b11);
    check("wr_addr_a", addr_a, 10'h005);
    check("wr_din_a", data_in_a, 16'h1234);
    check("wr_en_b_idle", {en_b, we_b}, 2'b00);
    set_req(2, 1'b0, 10'h005, 16'h0000);
    step();
    check("rd_en_a", {en_a, we_a}, 2'b10);
    repeat (3) step();

    // Reset while two reads are in flight
    set_req(0, 1'b0, 10'h005, 16'h0);
    set_req(1, 1'b0, 10'h005, 16'h0);
    step();
    check("mid_rd_issued", {en_a, en_b}, 2'b11);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin exp_d[i].delete(); exp_c[i].delete(); end
    ref_rr = 0;
    #1;
    check("rst_mid_en", {en_a, en_b}, 2'b00);
    check("rst_mid_rvalid", cl_rvalid, '0);
    @(negedge clk);
    check("rst_mid_rvalid2", cl_rvalid, '0);
    check("rst_mid_en2", {en_a, en_b}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Fairness: everyone re-requests every cycle
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 10'h005, 16'h0);
      step();
    end
    d_req = '0;
    repeat (3) step();

    // Dual same-cycle return to clients 1 and 3
    set_req(1, 1'b1, 10'h010, 16'hA1A1);
    set_req(3, 1'b1, 10'h011, 16'hB3B3);
    step();
    set_req(1, 1'b0, 10'h010, 16'h0);
    set_req(3, 1'b0, 10'h011, 16'h0);
    step();
    repeat (3) step();

    // Write/read to one address from clients 0 and 1 in the same cycle
`ifndef DP_BRAM_ARB_COLLISION_EN
    set_req(2, 1'b1, 10'h020, 16'hBEEF);
    step();
`endif
    set_req(0, 1'b1, 10'h020, 16'hBEEF);
    set_req(1, 1'b0, 10'h020, 16'h0);
    step();
    step();
    repeat (3) step();

    // Randomised traffic, each client in its own address quarter
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!d_req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), {2'(i), 8'($urandom)}, 16'($urandom));
      end
      step();
    end
    d_req = '0;
    repeat (6) step();
    for (int i = 0; i < N; i++) check($sformatf("drain_c%0d", i), exp_d[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
